// File: rtl/bcd_down_counter_pkg.sv
// Shared types and constants for the cascadable BCD down counter.
// Operation codes name the single action the counter takes on each clock edge.
package bcd_down_counter_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [2:0] {
    OP_HOLD,    // nothing to do, or an enabled count parked at zero
    OP_LOAD,    // accepted preset
    OP_REJECT,  // preset with a non-decimal nibble
    OP_COUNT,   // ordinary decrement of a non-zero value
    OP_RELOAD   // enabled count at zero with auto-reload
  } op_e;

  function automatic logic is_bcd(input bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_down_counter_digit_down.sv
// One BCD decade of the down counter: borrow-driven decrement plus a
// validity flag for the matching preset nibble.
module bcd_digit_down
  import bcd_down_counter_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       borrow_in,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit_next,
  output logic       borrow_out,
  output logic       load_invalid
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    digit_next = digit;
    if (borrow_in) begin
      digit_next = (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
    end
  end

  assign borrow_out   = borrow_in && (digit == 4'd0);
  assign load_invalid = !is_bcd(load_digit);

endmodule

// File: rtl/bcd_down_counter.sv
// Synchronous cascadable BCD down counter with validated preset load,
// optional auto-reload from the last accepted preset, and tc/err pulses.
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  auto_reload,
  output logic [4*DIGITS-1:0]   q,
  output logic                  zero,
  output logic                  tc,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      reload_q;
  logic [W-1:0]      q_dec;
  logic [DIGITS:0]   borrow;
  logic [DIGITS-1:0] nib_bad;
  logic              load_ok;
  logic              dec_to_zero;
  op_e               op;

  // The LS decade always receives a borrow: that is the decrement itself.
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_down u_digit (
      .digit        (q[4*i +: 4]),
      .borrow_in    (borrow[i]),
      .load_digit   (load_val[4*i +: 4]),
      .digit_next   (q_dec[4*i +: 4]),
      .borrow_out   (borrow[i+1]),
      .load_invalid (nib_bad[i])
    );
  end

  assign load_ok     = (nib_bad == '0);
  assign dec_to_zero = (q_dec == '0);

  // A borrow escapes the MS decade exactly when every digit is 0.
  assign zero = borrow[DIGITS];

  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = load_ok ? OP_LOAD : OP_REJECT;
    end else if (en) begin
      if (!zero) begin
        op = OP_COUNT;
      end else if (auto_reload) begin
        op = OP_RELOAD;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q        <= '0;
      // NOTE: the reload register is cleared by reset because a reload before any load must yield 0.
      reload_q <= '0;
      tc       <= 1'b0;
      err      <= 1'b0;
    end else begin
      tc  <= 1'b0;
      err <= 1'b0;
      unique case (op)
        OP_LOAD: begin
          q        <= load_val;
          reload_q <= load_val;
        end
        OP_REJECT: err <= 1'b1;
        OP_COUNT: begin
          q  <= q_dec;
          tc <= dec_to_zero;
        end
        OP_RELOAD: q <= reload_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench: a 2-digit and a 3-digit counter share stimulus and are
// compared every cycle against an integer-arithmetic model of the counter.
module tb_bcd_down_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        auto_reload = 1'b0;
  logic [11:0] load_val = '0;

  logic [7:0]  q2;
  logic        zero2, tc2, err2;
  logic [11:0] q3;
  logic        zero3, tc3, err3;

  int checks = 0;
  int failures = 0;

  // Model state: index 0 is the 2-digit counter, index 1 the 3-digit one.
  int m_val[2] = '{0, 0};
  int m_rel[2] = '{0, 0};
  bit m_tc[2]  = '{0, 0};
  bit m_err[2] = '{0, 0};

  logic [11:0] e2, e3;

  always #5 clk = ~clk;

  bcd_down_counter u_dut2 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val[7:0]),
    .auto_reload(auto_reload), .q(q2), .zero(zero2), .tc(tc2), .err(err2)
  );

  bcd_down_counter #(.DIGITS(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .auto_reload(auto_reload), .q(q3), .zero(zero3), .tc(tc3), .err(err3)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bcd_ok(input logic [11:0] v, input int nd);
    for (int i = 0; i < nd; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [11:0] v, input int nd);
    int r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [11:0] int2bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  task automatic model_step(input int k);
    int nd;
    logic [11:0] lv;
    nd = k + 2;
    lv = (k == 0) ? {4'h0, load_val[7:0]} : load_val;
    m_tc[k]  = 1'b0;
    m_err[k] = 1'b0;
    if (load) begin
      if (bcd_ok(lv, nd)) begin
        m_val[k] = bcd2int(lv, nd);
        m_rel[k] = m_val[k];
      end else begin
        m_err[k] = 1'b1;
      end
    end else if (en) begin
      if (m_val[k] != 0) begin
        m_val[k] = m_val[k] - 1;
        m_tc[k]  = (m_val[k] == 0);
      end else if (auto_reload) begin
        m_val[k] = m_rel[k];
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_val[k] = 0; m_rel[k] = 0; m_tc[k] = 1'b0; m_err[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  always @(negedge clk) begin
    e2 = int2bcd(m_val[0]);
    e3 = int2bcd(m_val[1]);
    check("cycle_d2", {5'b0, q2, zero2, tc2, err2},
          {5'b0, e2[7:0], m_val[0] == 0, m_tc[0], m_err[0]});
    check("cycle_d3", {1'b0, q3, zero3, tc3, err3},
          {1'b0, e3, m_val[1] == 0, m_tc[1], m_err[1]});
  end

  task automatic drive(input logic l, input logic [11:0] v, input logic e, input logic ar);
    @(negedge clk);
    #1;
    load = l; load_val = v; en = e; auto_reload = ar;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // 1: reset, then preset
    repeat (2) @(negedge clk);
    #1;
    check("rst_q", {8'h0, q2}, 16'h0000);
    check("rst_zero", {15'h0, zero2}, 16'h0001);
    rst = 1'b1;
    drive(1'b1, 12'h025, 1'b0, 1'b0);
    check("load25_q", {8'h0, q2}, 16'h0025);
    check("load25_zero_tc", {14'h0, zero2, tc2}, 16'h0000);
    check("model_load25", 16'(m_val[0]), 16'd25);

    // 2: borrow chain
    drive(1'b1, 12'h010, 1'b0, 1'b0);
    drive(1'b0, 12'h010, 1'b1, 1'b0);
    check("borrow_09", {8'h0, q2}, 16'h0009);
    drive(1'b0, 12'h010, 1'b1, 1'b0);
    check("borrow_08", {8'h0, q2}, 16'h0008);
    drive(1'b1, 12'h100, 1'b0, 1'b0);
    drive(1'b0, 12'h100, 1'b1, 1'b0);
    check("borrow_099", {4'h0, q3}, 16'h0099);
    check("model_099", 16'(m_val[1]), 16'd99);

    // 3: terminal count without reload
    drive(1'b1, 12'h002, 1'b0, 1'b0);
    drive(1'b0, 12'h002, 1'b1, 1'b0);
    check("tc_01", {7'h0, q2, tc2}, {7'h0, 8'h01, 1'b0});
    drive(1'b0, 12'h002, 1'b1, 1'b0);
    check("tc_00_pulse", {6'h0, q2, zero2, tc2}, {6'h0, 8'h00, 1'b1, 1'b1});
    drive(1'b0, 12'h002, 1'b1, 1'b0);
    check("tc_00_hold1", {6'h0, q2, zero2, tc2}, {6'h0, 8'h00, 1'b1, 1'b0});
    drive(1'b0, 12'h002, 1'b1, 1'b0);
    check("tc_00_hold2", {6'h0, q2, zero2, tc2}, {6'h0, 8'h00, 1'b1, 1'b0});

    // 4: auto-reload, period 4
    drive(1'b1, 12'h003, 1'b0, 1'b1);
    drive(1'b0, 12'h003, 1'b1, 1'b1);
    check("ar_02", {8'h0, q2}, 16'h0002);
    drive(1'b0, 12'h003, 1'b1, 1'b1);
    check("ar_01", {8'h0, q2}, 16'h0001);
    drive(1'b0, 12'h003, 1'b1, 1'b1);
    check("ar_00_tc", {7'h0, q2, tc2}, {7'h0, 8'h00, 1'b1});
    check("model_ar_tc", {15'h0, m_tc[0]}, 16'h0001);
    drive(1'b0, 12'h003, 1'b1, 1'b1);
    check("ar_reload_03", {7'h0, q2, tc2}, {7'h0, 8'h03, 1'b0});
    drive(1'b0, 12'h003, 1'b1, 1'b1);
    check("ar_02_again", {8'h0, q2}, 16'h0002);

    // 5: invalid load keeps value and previous preset
    drive(1'b1, 12'h007, 1'b0, 1'b1);
    drive(1'b1, 12'h01A, 1'b0, 1'b1);
    check("bad_load_q", {8'h0, q2}, 16'h0007);
    check("bad_load_err", {15'h0, err2}, 16'h0001);
    drive(1'b0, 12'h01A, 1'b1, 1'b1);
    check("bad_load_err_clr", {7'h0, q2, err2}, {7'h0, 8'h06, 1'b0});
    repeat (6) drive(1'b0, 12'h01A, 1'b1, 1'b1);
    check("bad_load_at0_tc", {7'h0, q2, tc2}, {7'h0, 8'h00, 1'b1});
    drive(1'b0, 12'h01A, 1'b1, 1'b1);
    check("bad_load_reload_07", {8'h0, q2}, 16'h0007);

    // 6: asynchronous reset mid-count, then load/en collision
    drive(1'b1, 12'h009, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 12'h009, 1'b1, 1'b0);
    check("pre_rst_05", {8'h0, q2}, 16'h0005);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst", {6'h0, q2, zero2, tc2}, {6'h0, 8'h00, 1'b1, 1'b0});
    @(negedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 12'h040, 1'b1, 1'b0);
    check("collision_40", {8'h0, q2}, 16'h0040);
    check("collision_040", {4'h0, q3}, 16'h0040);

    // Randomized phase: the per-cycle compare process does the checking.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      #1;
      rst = ($urandom_range(0, 149) != 0);
      load = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) auto_reload = ~auto_reload;
      for (int d = 0; d < 3; d++) begin
        load_val[4*d +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 3) == 0) load_val = 12'h001;
    end
    @(negedge clk);
    #1;
    rst = 1'b1; load = 1'b0; en = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
